// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection pipeline and its loaders.
package edge_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } loader_state_e;

  localparam int unsigned DROP_COUNT_W = 16;

endpackage

// File: rtl/raster_counter.sv
// Raster-order row/column cursor with enable, clear, column wrap and
// last-pixel flags. A clear together with an enable yields the position
// after (0,0), so a start-of-frame beat written at (0,0) leaves the cursor
// pointing at the next pixel.
module raster_counter #(
  parameter int unsigned HEIGHT = 50,
  parameter int unsigned WIDTH  = 50,
  parameter int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  parameter int unsigned COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             wrap,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);

  logic [ROW_W-1:0] base_row, row_nxt;
  logic [COL_W-1:0] base_col, col_nxt;

  assign wrap = (col == COL_MAX);
  assign last = wrap && (row == ROW_MAX);

  // Next cursor position: optional clear to origin, then optional advance.
  always_comb begin
    base_row = clear ? '0 : row;
    base_col = clear ? '0 : col;
    row_nxt  = base_row;
    col_nxt  = base_col;
    if (en) begin
      if (base_col == COL_MAX) begin
        col_nxt = '0;
        row_nxt = (base_row == ROW_MAX) ? '0 : base_row + 1'b1;
      end else begin
        col_nxt = base_col + 1'b1;
      end
    end
  end

  // Cursor register.
  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_nxt;
      col <= col_nxt;
    end
  end

endmodule

// File: rtl/frame_stream_loader.sv
// Assembles a raster-order pixel stream (valid/ready, start-of-frame marker)
// into a parallel HEIGHT x WIDTH frame and holds it until acknowledged.
// Optional macro FRAME_LOADER_DOUBLE_BUFFER_EN: ping-pong banks so the next
// frame can load while the previous one is presented.
module frame_stream_loader
  import edge_pkg::*;
#(
  parameter int unsigned HEIGHT      = 50,
  parameter int unsigned WIDTH       = 50,
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [PIXEL_WIDTH-1:0]                        s_pixel,
  input  logic                                          s_valid,
  input  logic                                          s_sof,
  output logic                                          s_ready,
  output logic [HEIGHT-1:0][WIDTH-1:0][PIXEL_WIDTH-1:0] frame_out,
  output logic                                          frame_valid,
  input  logic                                          frame_ack,
  output logic                                          sof_error,
  output logic [DROP_COUNT_W-1:0]                       drop_count
);

  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic SINGLE_PIXEL = (HEIGHT == 1) && (WIDTH == 1);

  loader_state_e    state, state_nxt;
  logic             accept, wr_en, cnt_en, cnt_clr, drop_inc, sof_err_nxt;
  logic             complete, wr_last, cnt_wrap, cnt_last;
  logic [ROW_W-1:0] cnt_row, wr_row;
  logic [COL_W-1:0] cnt_col, wr_col;

  raster_counter #(
    .HEIGHT(HEIGHT),
    .WIDTH (WIDTH),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_cursor (
    .clk  (clk),
    .reset(reset),
    .en   (cnt_en),
    .clear(cnt_clr),
    .row  (cnt_row),
    .col  (cnt_col),
    .wrap (cnt_wrap),
    .last (cnt_last)
  );

  // A start-of-frame beat always lands at the origin, otherwise at the cursor.
  assign wr_row  = s_sof ? '0 : cnt_row;
  assign wr_col  = s_sof ? '0 : cnt_col;
  assign wr_last = s_sof ? SINGLE_PIXEL : (cnt_wrap && cnt_last);

  // Next-state and per-beat control decode.
  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    drop_inc    = 1'b0;
    sof_err_nxt = 1'b0;
    accept      = s_valid && s_ready;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (s_sof) begin
            wr_en     = 1'b1;
            cnt_clr   = 1'b1;
            cnt_en    = 1'b1;
            state_nxt = LOAD;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en  = 1'b1;
          cnt_en = 1'b1;
          if (s_sof) begin
            cnt_clr     = 1'b1;
            sof_err_nxt = (cnt_row != '0) || (cnt_col != '0);
          end
        end
      end
      FULL: begin
        if (frame_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    complete = wr_en && wr_last;
    if (complete) begin
`ifdef FRAME_LOADER_DOUBLE_BUFFER_EN
      state_nxt = (frame_valid && !frame_ack) ? FULL : IDLE;
`else
      state_nxt = FULL;
`endif
    end
  end

  // State register. s_ready is registered from the next state so it stays low
  // through reset and never depends combinationally on s_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      s_ready <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt != FULL);
    end
  end

  // Restart error pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sof_error  <= 1'b0;
      drop_count <= '0;
    end else begin
      sof_error <= sof_err_nxt;
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

`ifdef FRAME_LOADER_DOUBLE_BUFFER_EN
  logic [HEIGHT-1:0][WIDTH-1:0][PIXEL_WIDTH-1:0] bank0, bank1;
  logic load_sel, show_sel;

  assign frame_out = show_sel ? bank1 : bank0;

  // Ping-pong storage: a completed bank is presented at once if nothing is
  // showing, otherwise it waits in FULL until the current frame is acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank0       <= '0;
      bank1       <= '0;
      load_sel    <= 1'b0;
      show_sel    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        if (load_sel) bank1[wr_row][wr_col] <= s_pixel;
        else          bank0[wr_row][wr_col] <= s_pixel;
      end
      if (complete && !(frame_valid && !frame_ack)) begin
        show_sel    <= load_sel;
        load_sel    <= ~load_sel;
        frame_valid <= 1'b1;
      end else if ((state == FULL) && frame_ack) begin
        show_sel <= load_sel;
        load_sel <= ~load_sel;
      end else if (frame_ack) begin
        frame_valid <= 1'b0;
      end
    end
  end
`else
  logic [HEIGHT-1:0][WIDTH-1:0][PIXEL_WIDTH-1:0] frame_q;

  assign frame_out = frame_q;

  // Single frame buffer, presented from completion until acknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q     <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (wr_en) frame_q[wr_row][wr_col] <= s_pixel;
      if (complete)                           frame_valid <= 1'b1;
      else if ((state == FULL) && frame_ack) frame_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_frame_stream_loader.sv
// Directed bench for frame_stream_loader at 4x4; covers the single-bank build
// by default and the ping-pong build when FRAME_LOADER_DOUBLE_BUFFER_EN is set.
module tb_frame_stream_loader;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           s_pixel;
  logic                 s_valid, s_sof, s_ready;
  logic [3:0][3:0][7:0] frame_out;
  logic                 frame_valid, frame_ack, sof_error;
  logic [15:0]          drop_count;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned sof_pulses = 0;

  typedef struct {
    logic       valid;
    logic       sof;
    logic [7:0] pix;
    logic       ack;
    logic       exp_ready;
    logic       exp_fv;
    logic       exp_err;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs[20];

  frame_stream_loader #(.HEIGHT(4), .WIDTH(4), .PIXEL_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_pixel    (s_pixel),
    .s_valid    (s_valid),
    .s_sof      (s_sof),
    .s_ready    (s_ready),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .sof_error  (sof_error),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sof_error === 1'b1) sof_pulses++;
  endtask

  task automatic check_frame(input string name, input logic [7:0] base, input bit zero);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] exp;
        exp = zero ? 8'h00 : base + 8'(4 * r + c);
        check($sformatf("%s[%0d][%0d]", name, r, c), 32'(frame_out[r][c]), 32'(exp));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    check({tag, "_sof_err"}, 32'(sof_error), 32'd0);
    check({tag, "_drop"}, 32'(drop_count), 32'd0);
    check_frame({tag, "_frame"}, 8'h00, 1'b1);
  endtask

  task automatic send_beat(input logic [7:0] pix, input logic sof);
    int unsigned waited = 0;
    while (s_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (s_ready !== 1'b1) begin
      total++;
      $display("FAIL ready_timeout: s_ready=%0b after %0d cycles, expected 1", s_ready, waited);
      return;
    end
    s_valid = 1'b1;
    s_sof   = sof;
    s_pixel = pix;
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gaps, input bit ack_in_gaps);
    for (int i = 0; i < 16; i++) begin
      send_beat(base + 8'(i), (i == 0));
      if (gaps && i != 15) begin
        int unsigned n;
        n = $urandom_range(0, 2);
        frame_ack = ack_in_gaps;
        repeat (n) tick();
        frame_ack = 1'b0;
      end
    end
  endtask

  task automatic ack_frame(input string tag);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check({tag, "_ack_fv"}, 32'(frame_valid), 32'd0);
    check({tag, "_ack_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; s_pixel = '0; s_valid = 1'b0; s_sof = 1'b0; frame_ack = 1'b0;
    tick();
    tick();
    check_reset_state("por");
    reset = 1'b0;
    tick();
    check("ready_after_reset", 32'(s_ready), 32'd1);

`ifdef FRAME_LOADER_DOUBLE_BUFFER_EN
    send_frame(8'h10, 1'b0, 1'b0);
    check("db_f1_fv", 32'(frame_valid), 32'd1);
    check("db_f1_ready", 32'(s_ready), 32'd1);
    check_frame("db_f1", 8'h10, 1'b0);
    send_frame(8'h20, 1'b0, 1'b0);
    check("db_f2_fv", 32'(frame_valid), 32'd1);
    check("db_f2_ready", 32'(s_ready), 32'd0);
    check_frame("db_f2_hold", 8'h10, 1'b0);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("db_swap_fv", 32'(frame_valid), 32'd1);
    check("db_swap_ready", 32'(s_ready), 32'd1);
    check_frame("db_swap", 8'h20, 1'b0);
    ack_frame("db_last");
`else
    // Back-to-back frame, then held/ignored beats and acks, as a vector table.
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, (i == 0), 8'(i), 1'b0, (i < 15), (i == 15), 1'b0, 16'd0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[17] = '{1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    for (int i = 0; i < 20; i++) begin
      s_valid = vecs[i].valid; s_sof = vecs[i].sof; s_pixel = vecs[i].pix; frame_ack = vecs[i].ack;
      tick();
      check($sformatf("v%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_fv", i), 32'(frame_valid), 32'(vecs[i].exp_fv));
      check($sformatf("v%0d_err", i), 32'(sof_error), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_drop", i), 32'(drop_count), 32'(vecs[i].exp_drop));
      if (i == 17) check_frame("b2b_held", 8'h00, 1'b0);
    end
    s_valid = 1'b0; s_sof = 1'b0; frame_ack = 1'b0;
    check_frame("b2b_after_ack", 8'h00, 1'b0);

    // Beats before SOF are dropped and counted.
    sof_pulses = 0;
    s_valid = 1'b1; s_sof = 1'b0; s_pixel = 8'h77;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("drop_%0d", k + 1), 32'(drop_count), 32'(k + 1));
    end
    s_valid = 1'b0;
    send_frame(8'h30, 1'b0, 1'b0);
    check("drop_frame_fv", 32'(frame_valid), 32'd1);
    check("drop_final", 32'(drop_count), 32'd3);
    check("drop_no_sof_err", 32'(sof_pulses), 32'd0);
    check_frame("drop_frame", 8'h30, 1'b0);
    ack_frame("drop");

    // Mid-frame SOF restarts loading and pulses sof_error once.
    sof_pulses = 0;
    send_beat(8'hA0, 1'b1);
    for (int i = 1; i < 5; i++) send_beat(8'hA0 + 8'(i), 1'b0);
    send_beat(8'h50, 1'b1);
    check("restart_pulse", 32'(sof_error), 32'd1);
    for (int i = 1; i < 16; i++) send_beat(8'h50 + 8'(i), 1'b0);
    check("restart_pulse_count", 32'(sof_pulses), 32'd1);
    check("restart_fv", 32'(frame_valid), 32'd1);
    check_frame("restart", 8'h50, 1'b0);
    ack_frame("restart");

    // Stray ack while idle, then a gapped frame with acks during the gaps.
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("stray_ack_fv", 32'(frame_valid), 32'd0);
    check("stray_ack_ready", 32'(s_ready), 32'd1);
    send_frame(8'h00, 1'b1, 1'b1);
    check("gap_fv", 32'(frame_valid), 32'd1);
    check("gap_ready", 32'(s_ready), 32'd0);
    check_frame("gap", 8'h00, 1'b0);
    ack_frame("gap");

    // Reset in the middle of a frame, then a clean frame.
    for (int i = 0; i < 7; i++) send_beat(8'h60 + 8'(i), (i == 0));
    reset = 1'b1;
    tick();
    check_reset_state("mid_reset");
    reset = 1'b0;
    tick();
    send_frame(8'h80, 1'b0, 1'b0);
    check("post_reset_fv", 32'(frame_valid), 32'd1);
    check_frame("post_reset", 8'h80, 1'b0);
    ack_frame("post_reset");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule
